// File: rtl/imem_pkg.sv
// Shared instruction-memory definitions used by the loader, the datapath fetch path and the memory.
package imem_pkg;

  localparam int unsigned IMEM_DEPTH  = 16;
  localparam int unsigned IMEM_ADDR_W = 4;
  localparam int unsigned INSTR_W     = 32;

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StData,
    StWrite,
    StCheck,
    StDone,
    StError
  } loader_state_e;

endpackage

// File: rtl/imem_word_assembler.sv
// Big-endian byte-to-word assembler: first byte of a word lands in the top byte.
module imem_word_assembler
  import imem_pkg::*;
#(
  parameter int unsigned DataW = INSTR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             shift_i,
  input  logic [7:0]       byte_i,
  output logic [DataW-1:0] word_o,
  output logic             word_ready_o
);

  localparam int unsigned CntW = $clog2(DataW / 8);

  // Only the leading bytes are stored; the final byte completes the word combinationally.
  logic [DataW-9:0] sr_q;
  logic [CntW-1:0]  cnt_q;

  assign word_o       = {sr_q, byte_i};
  assign word_ready_o = shift_i && (&cnt_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (shift_i) begin
      sr_q  <= {sr_q[DataW-17:0], byte_i};
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader writing the instruction memory and holding the CPU until loaded.
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned Depth = IMEM_DEPTH,
  parameter int unsigned AddrW = IMEM_ADDR_W,
  parameter int unsigned DataW = INSTR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             in_valid_i,
  input  logic [7:0]       in_data_i,
  output logic             in_ready_o,
  output logic             wr_en_o,
  output logic [AddrW-1:0] wr_addr_o,
  output logic [DataW-1:0] wr_data_o,
  output logic             cpu_hold_o,
  output logic             done_o,
  output logic             err_o,
  output logic [AddrW:0]   word_count_o
);

  localparam logic [7:0]   DepthByte = 8'(Depth);
  localparam logic [AddrW:0] DepthCnt = (AddrW + 1)'(Depth);

  loader_state_e    state_q;
  logic             in_ready_q, wr_en_q, cpu_hold_q, done_q, err_q;
  logic [AddrW-1:0] wr_addr_q;
  logic [DataW-1:0] wr_data_q;
  logic [AddrW:0]   word_count_q, n_q, cnt_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       csum_q;
`endif

  logic             accept, shift, clear, word_ready;
  logic [DataW-1:0] word;

  assign accept  = in_valid_i && in_ready_q;
  assign shift   = accept && (state_q == StData);
  assign clear   = start_i && (state_q inside {StIdle, StDone, StError});
  assign cnt_inc = (word_count_q == DepthCnt) ? word_count_q : word_count_q + 1'b1;

  imem_word_assembler #(
    .DataW(DataW)
  ) u_asm (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (clear),
    .shift_i     (shift),
    .byte_i      (in_data_i),
    .word_o      (word),
    .word_ready_o(word_ready)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      in_ready_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      word_count_q <= '0;
      n_q          <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        StIdle, StDone, StError: begin
          if (start_i) begin
            state_q      <= StHeader;
            in_ready_q   <= 1'b1;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            word_count_q <= '0;
            wr_addr_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
          end
        end
        StHeader: begin
          if (accept) begin
            if (in_data_i == 8'd0 || in_data_i > DepthByte) begin
              state_q    <= StError;
              in_ready_q <= 1'b0;
              err_q      <= 1'b1;
            end else begin
              n_q     <= in_data_i[AddrW:0];
              state_q <= StData;
            end
          end
        end
        StData: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (accept) csum_q <= csum_q ^ in_data_i;
`endif
          if (word_ready) begin
            state_q    <= StWrite;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b1;
            wr_data_q  <= word;
          end
        end
        StWrite: begin
          word_count_q <= cnt_inc;
          wr_addr_q    <= wr_addr_q + 1'b1;
          if (cnt_inc == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_q    <= StCheck;
            in_ready_q <= 1'b1;
`else
            state_q    <= StDone;
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
`endif
          end else begin
            state_q    <= StData;
            in_ready_q <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        StCheck: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            if (in_data_i == csum_q) begin
              state_q    <= StDone;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else begin
              state_q <= StError;
              err_q   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state_q    <= StIdle;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o   = in_ready_q;
  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign cpu_hold_o   = cpu_hold_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign word_count_o = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a queue-based model of expected writes.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, wr_en, cpu_hold, done, err;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  word_count;

  int checks = 0;
  int failures = 0;

  logic [35:0] exp_q[$];
  logic [31:0] wr_log[16];
  logic [7:0]  img[64];

  imem_loader dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .wr_en_o     (wr_en),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data),
    .cpu_hold_o  (cpu_hold),
    .done_o      (done),
    .err_o       (err),
    .word_count_o(word_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle monitor: every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset) begin
      chk("done_err_exclusive", {63'b0, done && err}, 64'd0);
      chk("cpu_hold_vs_done", {63'b0, cpu_hold}, {63'b0, !done});
      if (wr_en) begin
        chk("in_ready_low_in_write", {63'b0, in_ready}, 64'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {63'b0, wr_en}, 64'd0);
        end else begin
          logic [35:0] e;
          e = exp_q.pop_front();
          chk("wr_addr", {60'b0, wr_addr}, {60'b0, e[35:32]});
          chk("wr_data", {32'b0, wr_data}, {32'b0, e[31:0]});
        end
        wr_log[wr_addr] = wr_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got, rdy;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      got = rdy;
    end
    in_valid = 1'b0;
    if (!got) chk("byte_accept", {63'b0, got}, 64'd1);
  endtask

  function automatic logic [7:0] img_xor(input int n);
    logic [7:0] x = 8'h00;
    for (int j = 0; j < 4 * n; j++) x ^= img[j];
    return x;
  endfunction

  function automatic int pick_gap(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    return int'($urandom_range(0, 3));
  endfunction

  // gap_mode: 0 back-to-back, 1 alternate cycles, 2 random gaps.
  task automatic run_load(input int hdr, input int gap_mode, input bit bad_trailer,
                          input bit start_mid);
    bit hdr_ok, exp_done;
    int n;
    hdr_ok = (hdr >= 1 && hdr <= 16);
    n = hdr_ok ? hdr : 0;
    for (int i = 0; i < n; i++)
      exp_q.push_back({4'(i), img[4*i], img[4*i+1], img[4*i+2], img[4*i+3]});
    pulse_start();
    send_byte(8'(hdr), pick_gap(gap_mode));
    for (int j = 0; j < 4 * n; j++) begin
      send_byte(img[j], pick_gap(gap_mode));
      if (start_mid && j == 2) pulse_start();
    end
    exp_done = hdr_ok;
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (hdr_ok) send_byte(bad_trailer ? img_xor(n) ^ 8'h01 : img_xor(n), pick_gap(gap_mode));
    if (bad_trailer) exp_done = 1'b0;
`else
    if (bad_trailer) exp_done = hdr_ok;
`endif
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done || err) break;
    end
    chk("final_done", {63'b0, done}, {63'b0, exp_done});
    chk("final_err", {63'b0, err}, {63'b0, !exp_done});
    chk("final_cpu_hold", {63'b0, cpu_hold}, {63'b0, !exp_done});
    chk("final_word_count", {59'b0, word_count}, 64'(n));
    chk("final_in_ready", {63'b0, in_ready}, 64'd0);
    chk("writes_outstanding", 64'(exp_q.size()), 64'd0);
    repeat (4) tick();
    chk("no_late_write", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_values();
    chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
    chk("rst_wr_en", {63'b0, wr_en}, 64'd0);
    chk("rst_wr_addr", {60'b0, wr_addr}, 64'd0);
    chk("rst_wr_data", {32'b0, wr_data}, 64'd0);
    chk("rst_cpu_hold", {63'b0, cpu_hold}, 64'd1);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_err", {63'b0, err}, 64'd0);
    chk("rst_word_count", {59'b0, word_count}, 64'd0);
  endtask

  task automatic set_img(input logic [31:0] w0, input logic [31:0] w1);
    {img[0], img[1], img[2], img[3]} = w0;
    {img[4], img[5], img[6], img[7]} = w1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) wr_log[i] = '0;
    #12;
    check_reset_values();
    tick();
    reset = 1'b1;
    repeat (2) tick();
    chk("idle_in_ready", {63'b0, in_ready}, 64'd0);
    chk("idle_cpu_hold", {63'b0, cpu_hold}, 64'd1);

    // Two-word image, back-to-back bytes.
    set_img(32'h0000_0D10, 32'h0000_4D11);
    run_load(2, 0, 1'b0, 1'b0);
    chk("lit_word0", {32'b0, wr_log[0]}, 64'h0000_0D10);
    chk("lit_word1", {32'b0, wr_log[1]}, 64'h0000_4D11);

    // Same image, valid toggling, start pulsed mid-DATA.
    wr_log[0] = '0;
    wr_log[1] = '0;
    run_load(2, 1, 1'b0, 1'b1);
    chk("lit_toggle_word0", {32'b0, wr_log[0]}, 64'h0000_0D10);
    chk("lit_toggle_word1", {32'b0, wr_log[1]}, 64'h0000_4D11);

    // Bad headers, then recovery.
    run_load(0, 0, 1'b0, 1'b0);
    run_load(17, 0, 1'b0, 1'b0);
    for (int j = 0; j < 4; j++) img[j] = 8'($urandom);
    run_load(1, 2, 1'b0, 1'b0);

    // Full memory.
    for (int j = 0; j < 64; j++) img[j] = 8'($urandom);
    run_load(16, 2, 1'b0, 1'b0);
    chk("full_last_word", {32'b0, wr_log[15]}, {32'b0, img[60], img[61], img[62], img[63]});

    // Reset mid-DATA after two data bytes.
    pulse_start();
    send_byte(8'd1, 0);
    send_byte(8'hA5, 0);
    send_byte(8'h5A, 0);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values();
    #3;
    reset = 1'b1;
    repeat (2) tick();
    chk("post_rst_in_ready", {63'b0, in_ready}, 64'd0);
    chk("post_rst_cpu_hold", {63'b0, cpu_hold}, 64'd1);
    chk("post_rst_done", {63'b0, done}, 64'd0);
    set_img(32'hCAFE_F00D, 32'h0);
    run_load(1, 0, 1'b0, 1'b0);
    chk("post_rst_word0", {32'b0, wr_log[0]}, 64'hCAFE_F00D);

    // Randomized loads.
    for (int it = 0; it < 10; it++) begin
      int r, hdr;
      r = int'($urandom_range(0, 9));
      if (r == 0) hdr = 0;
      else if (r == 1) hdr = int'($urandom_range(17, 255));
      else hdr = int'($urandom_range(1, 16));
      for (int j = 0; j < 64; j++) img[j] = 8'($urandom);
      run_load(hdr, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    set_img(32'h1234_5678, 32'h0);
    chk("csum_model", {56'b0, img_xor(1)}, 64'h08);
    run_load(1, 0, 1'b0, 1'b0);
    run_load(1, 0, 1'b1, 1'b0);
    chk("csum_bad_hold", {63'b0, cpu_hold}, 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Byte-stream program loader; the writer side of the processor's 16-entry instruction memory, which the datapath fetch path reads.
- Accepts a length header and big-endian instruction bytes over a valid/ready link.
- Assembles the bytes into 32-bit words and writes them sequentially from address 0.
- Holds the processor in reset until the whole image has been written.

Parameters:
DEPTH, 16, number of instruction memory words
ADDR_W, 4, instruction memory address width (clog2 DEPTH)
DATA_W, 32, instruction word width

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR
in_valid  input  1  byte present on in_data
in_data  input  8  stream byte
in_ready  output  1  loader accepts byte this cycle
wr_en  output  1  instruction memory write strobe, one cycle per word
wr_addr  output  ADDR_W  write address
wr_data  output  DATA_W  write data
cpu_hold  output  1  high = processor held in reset
done  output  1  image loaded successfully (level)
err  output  1  load aborted (level)
word_count  output  ADDR_W+1  words written in current load

Behaviour:
- Reset values (reset low, asynchronous): state IDLE, in_ready 0, wr_en 0, wr_addr 0, wr_data 0, cpu_hold 1, done 0, err 0, word_count 0, byte counter 0, N 0.
- Byte transfer occurs only on a clk edge with in_valid && in_ready. in_data is ignored otherwise. in_ready does not depend combinationally on in_valid.
- IDLE:
  - in_ready 0, cpu_hold 1.
  - start -> HEADER; clears word_count, wr_addr, done, err.
- HEADER:
  - in_ready 1.
  - Accepted byte is N.
  - N==0 or N>DEPTH -> ERROR.
  - Otherwise latch N -> DATA.
- DATA:
  - in_ready 1.
  - Bytes shift into the assembly register MSB first (first byte = bits 31:24).
  - 2-bit byte counter.
  - On the 4th accepted byte -> WRITE.
- WRITE (exactly one cycle):
  - in_ready 0, wr_en 1, wr_data = assembled word, wr_addr = word_count[ADDR_W-1:0].
  - Next edge: word_count+1, wr_addr+1.
  - If the new count == N -> DONE (or CHECK when the optional feature is enabled); else -> DATA.
  - Write latency: wr_en is high the cycle after the 4th byte is accepted.
- DONE:
  - done 1, cpu_hold 0, in_ready 0.
  - Stays until start, then -> HEADER with cpu_hold back to 1 on the same edge.
- ERROR:
  - err 1, cpu_hold 1, in_ready 0.
  - Stays until start -> HEADER.
- start in HEADER/DATA/WRITE is ignored; a load is never restarted mid-stream.
- wr_addr wraps naturally, but never needs to: N<=DEPTH guarantees the last write is at address N-1.
- word_count saturates at DEPTH. It holds its final value in DONE/ERROR until the next start.
- Reset asserted mid-load: immediate return to reset values. Words already written stay in memory and are not cleared. The processor remains held (cpu_hold 1).
- Only one of done and err is ever high.

Optional Feature:
Macro: IMEM_LOADER_CHECKSUM_EN
- Enabled:
  - After the N-th word, state CHECK accepts one more byte (in_ready 1).
  - The byte must equal the XOR of all 4N data bytes, computed in a running 8-bit register cleared on start.
  - Match -> DONE. Mismatch -> ERROR; memory is already written, but cpu_hold stays 1.
- Disabled: no CHECK state, no checksum register; WRITE goes directly to DONE.

Decomposition:
- Shared package imem_pkg:
  - loader state enum (IDLE, HEADER, DATA, WRITE, CHECK, DONE, ERROR);
  - IMEM_DEPTH=16, IMEM_ADDR_W=4, INSTR_W=32;
  - shared with the datapath and instruction memory.
- One natural sub-module: imem_word_assembler (byte shift register + 2-bit counter, word_ready pulse). The FSM, handshake and counters remain in imem_loader.

Test Plan:
- Reset low mid-DATA after 2 bytes -> all outputs at reset values immediately; after release, state IDLE, cpu_hold 1; a subsequent start + N=1 load writes addr 0 correctly.
- start, stream 0x02, 0x00,0x00,0x0D,0x10, 0x00,0x00,0x4D,0x11 with in_valid always high -> wr_en at addr0 data 0x00000D10, then addr1 data 0x00004D11; done 1, cpu_hold 0, word_count 2; in_ready low during each WRITE cycle.
- Same stream with in_valid toggling every other cycle, plus start pulsed during DATA -> identical writes and final state; start has no effect.
- Header 0x00 -> err 1, no wr_en. Header 0x11 (17) -> err 1. A following start + valid N=1 load -> err clears, done 1.
- N=16, 64 bytes -> 16 writes at addr 0..15 in order, word_count 16, no wr_en after the 16th write, in_ready 0 in DONE.
- With IMEM_LOADER_CHECKSUM_EN, N=1 bytes 0x12,0x34,0x56,0x78: trailer 0x08 -> done 1; trailer 0x09 -> err 1, cpu_hold 1.
